// File: rtl/quad_spinner_emu.sv
// Multi-channel spinner emulator: mouse X deltas and joystick left/right become AB quadrature steps.
// Optional build macro SPINNER_ACCEL_EN doubles mouse deltas with magnitude above 16.
module quad_spinner_emu #(
    parameter int CHANNELS   = 2,
    parameter int POS_W      = 12,
    parameter int STEP_DIV   = 3000,
    parameter int JOY_PERIOD = 96000,
    parameter int SLOW_STEP  = 4,
    parameter int FAST_STEP  = 9
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   mouse_toggle,
    input  logic [9*CHANNELS-1:0] mouse_dx,
    input  logic [CHANNELS-1:0]   joy_right,
    input  logic [CHANNELS-1:0]   joy_left,
    input  logic [CHANNELS-1:0]   joy_fast,
    output logic [CHANNELS-1:0]   quad_a,
    output logic [CHANNELS-1:0]   quad_b,
    output logic [CHANNELS-1:0]   busy
);
    // Sum width holds any pos plus a (possibly doubled) 9-bit delta without overflow.
    localparam int SW    = ((POS_W > 11) ? POS_W : 11) + 1;
    localparam int DIV_W = $clog2(STEP_DIV + 1);
    localparam int JOY_W = $clog2(JOY_PERIOD + 1);
    localparam logic signed [SW-1:0] POS_MAX = SW'((1 << (POS_W - 1)) - 1);

    function automatic logic signed [POS_W-1:0] sat_pos(input logic signed [SW-1:0] v);
        if (v > POS_MAX)
            return POS_W'(POS_MAX);
        else if (v < -POS_MAX)
            return POS_W'(-POS_MAX);
        else
            return POS_W'(v);
    endfunction

    function automatic logic [1:0] enc_step(input logic [1:0] e, input logic up);
        logic [1:0] n;
        if (up) begin
            case (e)
                2'b00:   n = 2'b10;
                2'b10:   n = 2'b11;
                2'b11:   n = 2'b01;
                default: n = 2'b00;
            endcase
        end else begin
            case (e)
                2'b00:   n = 2'b01;
                2'b01:   n = 2'b11;
                2'b11:   n = 2'b10;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

`ifdef SPINNER_ACCEL_EN
    function automatic logic signed [SW-1:0] scale_dx(input logic signed [8:0] dx);
        if (dx > 9'sd16 || dx < -9'sd16)
            return SW'(dx) <<< 1;
        else
            return SW'(dx);
    endfunction
`else
    function automatic logic signed [SW-1:0] scale_dx(input logic signed [8:0] dx);
        return SW'(dx);
    endfunction
`endif

    logic [DIV_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == '0);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            pre_cnt <= '0;
        else if (pre_cnt == DIV_W'(STEP_DIV - 1))
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]              enc;
        logic signed [POS_W-1:0] pos;
        logic signed [POS_W-1:0] pos_step;
        logic signed [POS_W-1:0] pos_nxt;
        logic signed [POS_W-1:0] mag;
        logic                    busy_r;
        logic                    tog_q;
        logic                    tog_qq;
        logic signed [8:0]       dx_q;
        logic [JOY_W-1:0]        joy_cnt;
        logic                    joy_one;
        logic                    reload;
        logic                    mouse_evt;
        logic signed [SW-1:0]    dx_ext;
        logic signed [SW-1:0]    sum;

        assign joy_one   = joy_left[i] ^ joy_right[i];
        assign reload    = joy_one && (joy_cnt == JOY_W'(JOY_PERIOD - 1));
        assign mouse_evt = tog_q ^ tog_qq;

        // Resolution order: tick drain first, then mouse event, then joystick reload wins.
        always_comb begin
            pos_step = pos;
            if (tick && pos != '0) begin
                if (pos[POS_W-1])
                    pos_step = pos + POS_W'(1);
                else
                    pos_step = pos - POS_W'(1);
            end
            dx_ext  = scale_dx(dx_q);
            sum     = SW'(pos_step) + dx_ext;
            mag     = joy_fast[i] ? POS_W'(FAST_STEP) : POS_W'(SLOW_STEP);
            pos_nxt = pos_step;
            if (mouse_evt) begin
                if (pos_step == '0 || dx_q == '0 || pos_step[POS_W-1] == dx_q[8])
                    pos_nxt = sat_pos(sum);
                else
                    pos_nxt = sat_pos(dx_ext);
            end
            if (reload)
                pos_nxt = joy_left[i] ? -mag : mag;
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                enc     <= 2'b11;
                pos     <= '0;
                busy_r  <= 1'b0;
                tog_q   <= 1'b0;
                tog_qq  <= 1'b0;
                dx_q    <= '0;
                joy_cnt <= '0;
            end else begin
                tog_q  <= mouse_toggle[i];
                tog_qq <= tog_q;
                dx_q   <= mouse_dx[9*i +: 9];
                if (tick && pos != '0)
                    enc <= enc_step(enc, !pos[POS_W-1]);
                pos    <= pos_nxt;
                busy_r <= (pos_nxt != '0);
                if (!joy_one || reload)
                    joy_cnt <= '0;
                else
                    joy_cnt <= joy_cnt + 1'b1;
            end
        end

        assign quad_a[i] = enc[1];
        assign quad_b[i] = enc[0];
        assign busy[i]   = busy_r;
    end

endmodule

// File: doc/quad_spinner_emu.md
# quad_spinner_emu

Multi-channel spinner (rotary quadrature encoder) emulator for arcade cores. It converts PS/2 relative mouse X motion and digital joystick left/right into AB quadrature phase pairs that feed the game core's spinner inputs. It is a parametrised successor to the single-channel inline spinner logic: N channels, configurable rates and accumulator width, saturating accumulation and edge-symmetric mouse event detection. It sits between `hps_io` and the game core, in the `clk_sys` domain.

## Interface
- `CHANNELS`, 2: number of independent spinners.
- `POS_W`, 12: signed pending-step accumulator width per channel.
- `STEP_DIV`, 3000: `clk_sys` cycles per quadrature step (4 kHz at 12 MHz).
- `JOY_PERIOD`, 96000: `clk_sys` cycles between joystick reloads (8 ms at 12 MHz).
- `SLOW_STEP`, 4: joystick reload magnitude, normal speed.
- `FAST_STEP`, 9: joystick reload magnitude, fast button held.

- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `mouse_toggle` in CHANNELS: per-channel event toggle; any change marks a new packet.
- `mouse_dx` in 9*CHANNELS: per-channel signed X delta (two's complement); channel i occupies [9i+8:9i].
- `joy_right` in CHANNELS: hold for positive rotation.
- `joy_left` in CHANNELS: hold for negative rotation.
- `joy_fast` in CHANNELS: selects FAST_STEP.
- `quad_a` out CHANNELS: encoder phase A (bit 1 of the encoder state).
- `quad_b` out CHANNELS: encoder phase B (bit 0 of the encoder state).
- `busy` out CHANNELS: high while the channel accumulator is nonzero.

## Operation
- Per channel, the state is: enc[1:0], pos (signed POS_W), tog_q/tog_qq, dx_q, joy_cnt.
- A single shared prescaler counts 0..STEP_DIV-1 and wraps. `tick` is asserted when the count is 0.
- **Encoder step.** On `tick` with pos≠0, enc advances one state and pos moves one step toward 0.
  - pos>0: 00→10→11→01→00.
  - pos<0: 00→01→11→10→00.
  - pos=0: enc holds.
- **Mouse input.**
  - `mouse_toggle` and `mouse_dx` are registered once into tog_q and dx_q.
  - An event fires when tog_q≠tog_qq. Both toggle directions count.
  - On an event:
    - If sign(pos_next)=sign(dx) or pos_next=0: pos ← saturate(pos_next+dx).
    - Otherwise (direction reversal): pos ← dx, and pending opposite motion is discarded.
  - pos_next is pos after any same-cycle tick step.
  - Saturation limits: ±(2^(POS_W-1)-1). Value −2^(POS_W-1) is never produced.
- **Joystick input.**
  - Exactly one of left/right held: joy_cnt increments. At JOY_PERIOD-1 it wraps to 0 and pos ← ±(fast ? FAST_STEP : SLOW_STEP).
  - Neither or both held: joy_cnt ← 0, and no reload happens. Pending pos still drains.
- **Priority in one cycle:** joystick reload > mouse event > tick step.
  - The tick's enc advance still occurs when a reload or event overrides pos.
- **Reset.** All asserted asynchronously:
  - enc=2'b11, so quad_a=quad_b=1.
  - pos=0, busy=0.
  - Prescaler=0, joy_cnt=0.
  - tog_q/tog_qq=0, dx_q=0.
- Reset mid-drain discards all pending steps.

## Timing
- quad_a, quad_b and busy are registered outputs with no combinational path from inputs.
- Mouse latency:
  - A toggle change before edge N is registered at N.
  - The event is detected and pos is updated at N+1.
  - busy rises after N+1.
  - The first enc change occurs at the first tick at or after N+2.
- Step rate is exactly one enc transition per STEP_DIV cycles while busy.
- A burst of K steps drains in K ticks. busy falls in the cycle after the tick that makes pos=0.
- Joystick: the first reload occurs JOY_PERIOD cycles after the hold starts, then every JOY_PERIOD cycles.
- Channels are fully independent except for the shared prescaler, so ticks are simultaneous on all channels.

## Configuration
- `SPINNER_ACCEL_EN` defined:
  - Mouse deltas with |dx|>16 are doubled (dx<<1, sign-extended to POS_W) before accumulation.
  - Joystick is unaffected.
- `SPINNER_ACCEL_EN` undefined: dx is used unscaled. The doubling logic is not built.

## Test plan
Parameters for all scenarios: STEP_DIV=4, JOY_PERIOD=20, POS_W=6, CHANNELS=2.
- Reset, then idle 50 cycles → quad_a=quad_b=1 and busy=0 on both channels, with no enc changes.
- Channel 0: toggle with dx=+3 → busy rises. Over three ticks, 4 cycles apart, enc goes 11→01→00→10. Then busy=0 and enc holds 10. Channel 1 stays at 11.
- Channel 0: dx=+20, then a second toggle with dx=+20 before the drain completes → pos saturates at 31, and exactly 31 steps follow the second event, minus any ticks already consumed. Toggle a falling edge with dx=−2 during the drain → pos becomes −2 and the direction reverses.
- Channel 1: hold joy_left with joy_fast=1 for 45 cycles → pos reloads to −9 at cycles 20 and 40. enc walks the negative sequence. Releasing the button stops reloads, and the remaining steps drain.
- Same cycle: joystick reload (+4) and mouse event (dx=−7) on channel 0 → pos=+4.
- Assert reset while pos=12 mid-drain → pos=0, busy=0 and enc=11 immediately, with no step after release until new input.
